// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_LOAD,
        S_SETUP,
        S_EN,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } lcd_state_e;

    // Power-on init sequence: 8-bit/2-line, display on, clear, entry mode.
    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_CLEAR    = 8'h01;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;
    localparam int         INIT_LEN      = 4;

    // Instructions that need the long post-command wait.
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INIT_FUNC_SET;
            2'd1:    b = INIT_DISP_ON;
            2'd2:    b = INIT_CLEAR;
            default: b = INIT_ENTRY;
        endcase
        return b;
    endfunction

    // Only instructions (rs=0) clear/home are slow; the same codes as data are not.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && ((d == OP_CLEAR) || (d == OP_HOME));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable saturating down-counter. A state loaded with N lasts exactly N
// cycles: done_o is raised in the cycle the count reaches 1 (or sits at 0).
module lcd_timer #(
    parameter int W       = 8,
    parameter int RST_VAL = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, otherwise decrement and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register; reset preloads the power-on delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q <= W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only controller: power-on wait, fixed init sequence,
// then CPU bytes strobed with setup/enable/hold/busy-wait timing.
// Handshake: a request transfers on a cycle where cmd_valid_i && cmd_ready_o;
// the requester holds cmd_rs_i/cmd_data_i stable while cmd_valid_i is high and
// not yet accepted. cmd_ready_o is high only while idle.
import lcd_pkg::*;

module lcd_ctrl #(
    parameter int POWERUP_CYC    = 750000,
    parameter int SETUP_CYC      = 4,
    parameter int EN_CYC         = 12,
    parameter int HOLD_CYC       = 4,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    input  logic       cmd_rs_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       lcd_on_o,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o,
    output lcd_state_e dbg_state_o
);

    localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(EN_CYC, HOLD_CYC)),
                                  max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    lcd_state_e   state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic         rs_q, rs_d;
    logic [7:0]   data_q, data_d;
    logic         on_q, on_d;
    logic         tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic         tmr_done;

    lcd_timer #(
        .W       (CNT_W),
        .RST_VAL (POWERUP_CYC)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Next-state, holding-register and timer-load logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rs_d     = rs_q;
        data_d   = data_q;
        on_d     = 1'b1;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_POWERUP: begin
                if (tmr_done) state_d = S_LOAD;
            end
            S_LOAD: begin
                rs_d     = 1'b0;
                data_d   = init_byte(idx_q[1:0]);
                idx_d    = idx_q + 3'd1;
                state_d  = S_SETUP;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(SETUP_CYC);
            end
            S_SETUP: begin
                if (tmr_done) begin
                    state_d  = S_EN;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(EN_CYC);
                end
            end
            S_EN: begin
                if (tmr_done) begin
                    state_d  = S_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYC);
                end
            end
            S_HOLD: begin
                if (tmr_done) begin
                    state_d  = S_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(CLEAR_WAIT_CYC)
                                                         : CNT_W'(CMD_WAIT_CYC);
                end
            end
            S_WAIT: begin
                if (tmr_done) begin
                    state_d = (idx_q < 3'(INIT_LEN)) ? S_LOAD : S_IDLE;
                end
            end
            S_IDLE: begin
                if (cmd_valid_i) begin
                    rs_d     = cmd_rs_i;
                    data_d   = cmd_data_i;
                    state_d  = S_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(SETUP_CYC);
                end
            end
            default: state_d = S_POWERUP;
        endcase
    end

    // State and output holding registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_POWERUP;
            idx_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            on_q    <= on_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign lcd_en_o    = (state_q == S_EN);
    assign lcd_rs_o    = rs_q;
    assign lcd_data_o  = data_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_on_o    = on_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter POWERUP_CYC, default 750000: power-on wait in clk_i cycles (15 ms at 50 MHz).
REQ-002 Parameter SETUP_CYC, default 4: RS/DATA setup cycles before EN rises.
REQ-003 Parameter EN_CYC, default 12: EN high width in cycles.
REQ-004 Parameter HOLD_CYC, default 4: RS/DATA hold cycles after EN falls.
REQ-005 Parameter CMD_WAIT_CYC, default 2000: post-command busy wait (40 us).
REQ-006 Parameter CLEAR_WAIT_CYC, default 82000: post-wait for clear (0x01) and home (0x02) commands (1.64 ms).
REQ-007 clk_i  input  1  sole clock, rising edge.
REQ-008 rst_i  input  1  reset, synchronous and active-high.
REQ-009 cmd_valid_i  input  1  CPU-side request; held with its payload until accepted.
REQ-010 cmd_rs_i  input  1  0 = instruction, 1 = character data.
REQ-011 cmd_data_i  input  8  instruction or character byte.
REQ-012 cmd_ready_o  output  1  block accepts a request this cycle.
REQ-013 lcd_on_o  output  1  LCD power/backlight enable.
REQ-014 lcd_en_o  output  1  HD44780 enable strobe.
REQ-015 lcd_rs_o  output  1  HD44780 register select.
REQ-016 lcd_rw_o  output  1  HD44780 read/write; constant 0 (write only).
REQ-017 lcd_data_o  output  8  HD44780 data bus, 8-bit mode.

Function
REQ-018 FSM states SHALL be: S_POWERUP, S_LOAD, S_SETUP, S_EN, S_HOLD, S_WAIT, S_IDLE.
REQ-019 S_POWERUP SHALL last exactly POWERUP_CYC cycles, then go to S_LOAD with init index 0.
REQ-020 The init sequence SHALL be instructions 0x38, 0x0C, 0x01, 0x06, issued in order, each through S_SETUP->S_EN->S_HOLD->S_WAIT.
REQ-021 S_LOAD SHALL latch the next init byte (rs=0) into the output holding register in one cycle.
REQ-022 S_SETUP, S_EN and S_HOLD SHALL last exactly SETUP_CYC, EN_CYC and HOLD_CYC cycles; lcd_en_o SHALL be 1 only in S_EN.
REQ-023 lcd_rs_o/lcd_data_o SHALL be registered and stable from S_SETUP entry through S_HOLD exit.
REQ-024 S_WAIT SHALL last CLEAR_WAIT_CYC if the byte is an instruction equal to 0x01 or 0x02, else CMD_WAIT_CYC.
REQ-025 After S_WAIT, the FSM SHALL go to S_LOAD while init entries remain, else to S_IDLE.
REQ-026 cmd_ready_o SHALL be 1 only in S_IDLE; no request is accepted during init.
REQ-027 A transfer SHALL occur when cmd_valid_i && cmd_ready_o; payload captured that cycle, next state S_SETUP.
REQ-028 cmd_ready_o SHALL drop the cycle after acceptance and rise again on return to S_IDLE.
REQ-029 Back-to-back requests: valid held high SHALL see exactly one acceptance per full SETUP+EN+HOLD+WAIT sequence.
REQ-030 One down-counter SHALL time all states; width = $clog2(max parameter + 1); expiry at 0 without wrap.
REQ-031 lcd_on_o SHALL be 1 from the first cycle after reset release.
REQ-032 Changes on cmd_* while not ready SHALL have no effect.

Reset
REQ-033 With rst_i sampled high, outputs SHALL be: cmd_ready_o=0, lcd_en_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_data_o=0x00, lcd_on_o=0.
REQ-034 Reset SHALL enter S_POWERUP, clear the init index and reload the counter with POWERUP_CYC.
REQ-035 Reset asserted mid-strobe SHALL drop lcd_en_o on the next edge and discard the in-flight byte; the full init sequence SHALL rerun.

Structure
REQ-036 Package lcd_pkg SHALL hold the state enum, the init-ROM constants (0x38, 0x0C, 0x01, 0x06) and CLEAR/HOME opcode constants.
REQ-037 Sub-module lcd_timer (loadable down-counter, done flag) SHALL be the single natural sub-module.

Verification (override POWERUP=20, SETUP=2, EN=3, HOLD=2, CMD_WAIT=5, CLEAR_WAIT=10)
REQ-038 Reset release -> 20 cycles idle, then four EN pulses of 3 cycles with data 0x38, 0x0C, 0x01, 0x06; a 10-cycle wait after 0x01; then cmd_ready_o=1.
REQ-039 In IDLE, rs=1, data=0x41 -> lcd_rs_o=1, lcd_data_o=0x41 two cycles before EN rises and two after it falls; ready again after 5-cycle wait.
REQ-040 Held cmd_valid_i with 0x48, 0x49 switching on acceptance -> exactly two strobes, in order, no duplicates.
REQ-041 Instruction 0x01 from CPU -> 10-cycle wait; instruction 0x80 -> 5-cycle wait.
REQ-042 rst_i pulsed during S_EN of user byte -> lcd_en_o=0 next cycle, all outputs at reset values, init sequence rerun from 0x38.
REQ-043 cmd_valid_i=1 throughout init -> no acceptance until the first S_IDLE cycle.
